// File: rtl/nfc_command_responder.sv
// NAND command responder: takes one command, waits for the target way's R/B#, launches the engine, reports a 24-bit status.
// Optional watchdog on the WAITRB/EXEC waits is built when NFC_CMD_TIMEOUT_EN is defined.
module nfc_command_responder #(
  parameter int NumberOfWays  = 2,
  parameter int TimeoutCycles = 65535
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [4:0]              iSourceID,
  input  logic [31:0]             iAddress,
  input  logic [15:0]             iLength,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  output logic [23:0]             oStatus,
  output logic                    oStatusValid,
  input  logic [NumberOfWays-1:0] iReadyBusy,
  output logic [5:0]              oEngOpcode,
  output logic [NumberOfWays-1:0] oEngWaySelect,
  output logic [31:0]             oEngAddress,
  output logic [15:0]             oEngLength,
  output logic                    oEngStart,
  input  logic                    iEngDone,
  input  logic [7:0]              iEngStatus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAITRB,
    S_ISSUE,
    S_EXEC,
    S_REPORT
  } state_t;

  localparam logic [5:0] WayCount = 6'(NumberOfWays);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [5:0]              r_opcode;
  logic [4:0]              r_target;
  logic [4:0]              r_source;
  logic [31:0]             r_address;
  logic [15:0]             r_length;
  logic [23:0]             r_status;
  logic [NumberOfWays-1:0] w_way_onehot;
  logic                    w_way_ready;
  logic                    w_timeout_hit;
  logic                    w_capture;
  logic [4:0]              w_code;
  logic [7:0]              w_eng_status;
  logic                    w_engine_phase;
  logic                    w_unused_source;

  genvar gi;
  generate
    for (gi = 0; gi < NumberOfWays; gi = gi + 1) begin : g_way
      assign w_way_onehot[gi] = (r_target == 5'(gi));
    end
  endgenerate

  // Masking with the one-hot avoids an out-of-range index when the target is invalid.
  assign w_way_ready     = |(iReadyBusy & w_way_onehot);
  assign w_unused_source = ^r_source;

`ifdef NFC_CMD_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

  logic [15:0] r_timeout_count;
  logic        w_watch_state;

  assign w_watch_state = (r_state == S_WAITRB) || (r_state == S_EXEC);
  assign w_timeout_hit = w_watch_state && ((r_timeout_count + 16'd1) == TimeoutLimit);

  // Any state change restarts the count, so each WAITRB/EXEC visit starts at zero.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_timeout_count <= 16'd0;
    end else if (w_state_next != r_state) begin
      r_timeout_count <= 16'd0;
    end else if (w_watch_state) begin
      r_timeout_count <= r_timeout_count + 16'd1;
    end
  end
`else
  logic [15:0] w_unused_limit;

  assign w_unused_limit = 16'(TimeoutCycles);
  assign w_timeout_hit  = 1'b0;
`endif

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_code       = 5'd0;
    w_eng_status = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (iCMDValid) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if ({1'b0, r_target} >= WayCount) begin
          w_state_next = S_REPORT;
          w_capture    = 1'b1;
          w_code       = 5'd1;
        end else if (r_opcode == 6'd0) begin
          w_state_next = S_REPORT;
          w_capture    = 1'b1;
          w_code       = 5'd2;
        end else begin
          w_state_next = S_WAITRB;
        end
      end
      S_WAITRB: begin
        if (w_way_ready) begin
          w_state_next = S_ISSUE;
        end else if (w_timeout_hit) begin
          w_state_next = S_REPORT;
          w_capture    = 1'b1;
          w_code       = 5'd3;
        end
      end
      S_ISSUE: begin
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (iEngDone) begin
          w_state_next = S_REPORT;
          w_capture    = 1'b1;
          w_eng_status = iEngStatus;
        end else if (w_timeout_hit) begin
          w_state_next = S_REPORT;
          w_capture    = 1'b1;
          w_code       = 5'd3;
        end
      end
      S_REPORT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_opcode  <= 6'd0;
      r_target  <= 5'd0;
      r_source  <= 5'd0;
      r_address <= 32'd0;
      r_length  <= 16'd0;
      r_status  <= 24'd0;
    end else begin
      if ((r_state == S_IDLE) && iCMDValid) begin
        r_opcode  <= iOpcode;
        r_target  <= iTargetID;
        r_source  <= iSourceID;
        r_address <= iAddress;
        r_length  <= iLength;
      end
      if (w_capture) begin
        r_status <= {w_eng_status, r_opcode, r_target, w_code};
      end
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the edge.
  assign w_engine_phase = !iReset && ((r_state == S_ISSUE) || (r_state == S_EXEC));
  assign oCMDReady      = !iReset && (r_state == S_IDLE);
  assign oEngStart      = !iReset && (r_state == S_ISSUE);
  assign oStatusValid   = !iReset && (r_state == S_REPORT);
  assign oStatus        = iReset ? 24'd0 : r_status;
  assign oEngOpcode     = w_engine_phase ? r_opcode : 6'd0;
  assign oEngAddress    = w_engine_phase ? r_address : 32'd0;
  assign oEngLength     = w_engine_phase ? r_length : 16'd0;
  assign oEngWaySelect  = w_engine_phase ? w_way_onehot : '0;

endmodule

// File: tb/tb_nfc_command_responder.sv
// Directed bench for nfc_command_responder; each task drives one scenario and checks hand-computed values.
// The timeout scenario is selected by NFC_CMD_TIMEOUT_EN, matching the RTL build.
module tb_nfc_command_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [4:0]  tgt;
  logic [4:0]  src;
  logic [31:0] addr;
  logic [15:0] len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] status;
  logic        status_valid;
  logic [1:0]  ready_busy;
  logic [5:0]  eng_op;
  logic [1:0]  eng_way;
  logic [31:0] eng_addr;
  logic [15:0] eng_len;
  logic        eng_start;
  logic        eng_done;
  logic [7:0]  eng_status;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nfc_command_responder #(
    .NumberOfWays (2),
    .TimeoutCycles(20)
  ) dut (
    .iSystemClock (clk),
    .iReset       (rst),
    .iOpcode      (op),
    .iTargetID    (tgt),
    .iSourceID    (src),
    .iAddress     (addr),
    .iLength      (len),
    .iCMDValid    (cmd_valid),
    .oCMDReady    (cmd_ready),
    .oStatus      (status),
    .oStatusValid (status_valid),
    .iReadyBusy   (ready_busy),
    .oEngOpcode   (eng_op),
    .oEngWaySelect(eng_way),
    .oEngAddress  (eng_addr),
    .oEngLength   (eng_len),
    .oEngStart    (eng_start),
    .iEngDone     (eng_done),
    .iEngStatus   (eng_status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge (edge 0); returns in cycle 1 with garbage on the command bus.
  task automatic send_cmd(input logic [5:0] o, input logic [4:0] t, input logic [31:0] a, input logic [15:0] l);
    op = o; tgt = t; src = 5'h1F; addr = a; len = l; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; op = 6'h2A; tgt = 5'h1E; addr = 32'hDEADBEEF; len = 16'hBEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1;
    tick(); tick();
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
    vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", status_valid); end
    vectors++; if (status !== 24'h0) begin miscompares++; $display("FAIL reset_status got=%h exp=000000", status); end
    vectors++; if ({eng_start, eng_way, eng_op, eng_addr, eng_len} !== 57'd0) begin miscompares++; $display("FAIL reset_eng got=%b/%b/%h/%h/%h exp=0", eng_start, eng_way, eng_op, eng_addr, eng_len); end
    cmd_valid = 1'b0; rst = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    eng_status = 8'hFF;
    send_cmd(6'h05, 5'd1, 32'h00012345, 16'h0800);
    vectors++; if (cmd_ready !== 1'b0 || eng_start !== 1'b0) begin miscompares++; $display("FAIL nom_cycle1 ready=%b start=%b exp=0/0", cmd_ready, eng_start); end
    tick();
    vectors++; if (eng_start !== 1'b0) begin miscompares++; $display("FAIL nom_cycle2_start got=%b exp=0", eng_start); end
    tick();
    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL nom_cycle3_start got=%b exp=1", eng_start); end
    vectors++; if (eng_way !== 2'b10) begin miscompares++; $display("FAIL nom_way got=%b exp=10", eng_way); end
    vectors++; if (eng_op !== 6'h05 || eng_addr !== 32'h00012345 || eng_len !== 16'h0800) begin miscompares++; $display("FAIL nom_eng_fields got=%h/%h/%h exp=05/00012345/0800", eng_op, eng_addr, eng_len); end
    tick();
    vectors++; if (eng_start !== 1'b0 || eng_addr !== 32'h00012345 || eng_way !== 2'b10) begin miscompares++; $display("FAIL nom_exec_hold start=%b addr=%h way=%b exp=0/00012345/10", eng_start, eng_addr, eng_way); end
    tick();
    eng_done = 1'b1; eng_status = 8'hE0;
    tick();
    eng_done = 1'b0; eng_status = 8'hFF;
    vectors++; if (status_valid !== 1'b1) begin miscompares++; $display("FAIL nom_valid got=%b exp=1", status_valid); end
    vectors++; if (status !== 24'hE01420) begin miscompares++; $display("FAIL nom_status got=%h exp=e01420", status); end
    vectors++; if (eng_addr !== 32'h0 || eng_way !== 2'b00) begin miscompares++; $display("FAIL nom_report_eng addr=%h way=%b exp=0/00", eng_addr, eng_way); end
    tick();
    vectors++; if (status_valid !== 1'b0 || cmd_ready !== 1'b1 || status !== 24'hE01420) begin miscompares++; $display("FAIL nom_after valid=%b ready=%b status=%h exp=0/1/e01420", status_valid, cmd_ready, status); end
    $display("test_nominal done");
  endtask

  task automatic test_invalid();
    logic [5:0]  ops [4] = '{6'h05, 6'h03, 6'h00, 6'h00};
    logic [4:0]  tgts[4] = '{5'd3, 5'd2, 5'd1, 5'd5};
    logic [23:0] exps[4] = '{24'h001461, 24'h000C41, 24'h000022, 24'h0000A1};
    logic        saw_start;
    eng_status = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      send_cmd(ops[i], tgts[i], 32'h0000_1000, 16'h0010);
      saw_start = eng_start;
      vectors++; if (status_valid !== 1'b0) begin miscompares++; $display("FAIL inv%0d_cycle1_valid got=%b exp=0", i, status_valid); end
      tick();
      saw_start = saw_start | eng_start;
      vectors++; if (status_valid !== 1'b1) begin miscompares++; $display("FAIL inv%0d_cycle2_valid got=%b exp=1", i, status_valid); end
      vectors++; if (status !== exps[i]) begin miscompares++; $display("FAIL inv%0d_status got=%h exp=%h", i, status, exps[i]); end
      tick();
      saw_start = saw_start | eng_start;
      vectors++; if (cmd_ready !== 1'b1 || status_valid !== 1'b0) begin miscompares++; $display("FAIL inv%0d_cycle3 ready=%b valid=%b exp=1/0", i, cmd_ready, status_valid); end
      vectors++; if (saw_start !== 1'b0) begin miscompares++; $display("FAIL inv%0d_no_start got=%b exp=0", i, saw_start); end
    end
    $display("test_invalid done");
  endtask

  task automatic test_rb_wait();
    logic bad;
    ready_busy = 2'b10;
    send_cmd(6'h11, 5'd0, 32'hA5A5_0000, 16'h0200);
    bad = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      op = 6'h2A; tgt = 5'd1; cmd_valid = 1'b1;
      eng_done = (k == 5); eng_status = 8'h44;
      tick();
      if (cmd_ready !== 1'b0 || eng_start !== 1'b0 || status_valid !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL rb_busy_hold ready=%b start=%b valid=%b exp=0/0/0", cmd_ready, eng_start, status_valid); end
    eng_done = 1'b0; ready_busy = 2'b11;
    tick();
    cmd_valid = 1'b0;
    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL rb_start got=%b exp=1", eng_start); end
    vectors++; if (eng_op !== 6'h11 || eng_way !== 2'b01 || eng_addr !== 32'hA5A5_0000) begin miscompares++; $display("FAIL rb_fields op=%h way=%b addr=%h exp=11/01/a5a50000", eng_op, eng_way, eng_addr); end
    tick();
    eng_done = 1'b1; eng_status = 8'h5A;
    tick();
    eng_done = 1'b0;
    vectors++; if (status_valid !== 1'b1 || status !== 24'h5A4400) begin miscompares++; $display("FAIL rb_status valid=%b status=%h exp=1/5a4400", status_valid, status); end
    tick();
    $display("test_rb_wait done");
  endtask

`ifdef NFC_CMD_TIMEOUT_EN
  task automatic test_exec_wait();
    logic early;
    for (int pass = 0; pass < 2; pass++) begin
      send_cmd(6'h05, 5'd0, 32'h0, 16'h0001);
      tick(); tick();
      vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL to%0d_start got=%b exp=1", pass, eng_start); end
      early = 1'b0;
      for (int k = 4; k <= 23; k++) begin
        tick();
        if (status_valid !== 1'b0) early = 1'b1;
        if (pass == 1 && k == 23) begin eng_done = 1'b1; eng_status = 8'h77; end
      end
      vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL to%0d_early_report got=%b exp=0", pass, early); end
      tick();
      eng_done = 1'b0;
      vectors++; if (status_valid !== 1'b1 || status !== ((pass == 0) ? 24'h001403 : 24'h771400)) begin miscompares++; $display("FAIL to%0d_status valid=%b status=%h exp=1/%h", pass, status_valid, status, (pass == 0) ? 24'h001403 : 24'h771400); end
      tick();
    end
    $display("test_exec_wait (timeout) done");
  endtask
`else
  task automatic test_exec_wait();
    logic early;
    send_cmd(6'h05, 5'd0, 32'h0, 16'h0001);
    tick(); tick();
    vectors++; if (eng_start !== 1'b1) begin miscompares++; $display("FAIL wait_start got=%b exp=1", eng_start); end
    early = 1'b0;
    for (int k = 4; k <= 43; k++) begin
      tick();
      if (status_valid !== 1'b0 || cmd_ready !== 1'b0) early = 1'b1;
    end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL wait_no_timeout got=%b exp=0", early); end
    eng_done = 1'b1; eng_status = 8'h33;
    tick();
    eng_done = 1'b0;
    vectors++; if (status_valid !== 1'b1 || status !== 24'h331400) begin miscompares++; $display("FAIL wait_status valid=%b status=%h exp=1/331400", status_valid, status); end
    tick();
    $display("test_exec_wait (no timeout) done");
  endtask
`endif

  task automatic test_reset_exec();
    logic pulsed;
    send_cmd(6'h05, 5'd1, 32'h1111_2222, 16'h0040);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b0 || eng_way !== 2'b00 || eng_addr !== 32'h0) begin miscompares++; $display("FAIL rstx_during ready=%b way=%b addr=%h exp=0/00/0", cmd_ready, eng_way, eng_addr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b1 || status_valid !== 1'b0 || status !== 24'h0) begin miscompares++; $display("FAIL rstx_after ready=%b valid=%b status=%h exp=1/0/000000", cmd_ready, status_valid, status); end
    pulsed = 1'b0;
    eng_done = 1'b1; eng_status = 8'hAB;
    for (int k = 0; k < 5; k++) begin
      tick();
      eng_done = 1'b0;
      if (status_valid !== 1'b0) pulsed = 1'b1;
    end
    vectors++; if (pulsed !== 1'b0) begin miscompares++; $display("FAIL rstx_no_pulse got=%b exp=0", pulsed); end
    send_cmd(6'h3F, 5'd0, 32'h0000_0010, 16'h0004);
    tick(); tick();
    vectors++; if (eng_start !== 1'b1 || eng_way !== 2'b01) begin miscompares++; $display("FAIL rstx_next_start start=%b way=%b exp=1/01", eng_start, eng_way); end
    tick();
    eng_done = 1'b1; eng_status = 8'h01;
    tick();
    eng_done = 1'b0;
    vectors++; if (status_valid !== 1'b1 || status !== 24'h01FC00) begin miscompares++; $display("FAIL rstx_next_status valid=%b status=%h exp=1/01fc00", status_valid, status); end
    tick();
    $display("test_reset_exec done");
  endtask

  task automatic test_back_to_back();
    send_cmd(6'h00, 5'd1, 32'h0, 16'h0);
    tick();
    vectors++; if (status !== 24'h000022) begin miscompares++; $display("FAIL b2b_first got=%h exp=000022", status); end
    tick();
    send_cmd(6'h07, 5'd0, 32'h0000_7777, 16'h0007);
    tick(); tick();
    vectors++; if (eng_start !== 1'b1 || eng_op !== 6'h07 || status !== 24'h000022) begin miscompares++; $display("FAIL b2b_issue start=%b op=%h status=%h exp=1/07/000022", eng_start, eng_op, status); end
    tick();
    eng_done = 1'b1; eng_status = 8'h99;
    tick();
    eng_done = 1'b0;
    vectors++; if (status_valid !== 1'b1 || status !== 24'h991C00) begin miscompares++; $display("FAIL b2b_second valid=%b status=%h exp=1/991c00", status_valid, status); end
    tick();
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; op = '0; tgt = '0; src = '0; addr = '0; len = '0;
    ready_busy = 2'b11; eng_done = 1'b0; eng_status = '0;
    test_reset();
    test_nominal();
    test_invalid();
    test_rb_wait();
    test_exec_wait();
    test_reset_exec();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nfc_command_responder.md
NFC_COMMAND_RESPONDER -- requirements
Module: nfc_command_responder

Interface
REQ-001 SHALL have parameter NumberOfWays, default 2: number of NAND ways, 1..32.
REQ-002 SHALL have parameter TimeoutCycles, default 65535: watchdog limit, 16-bit.
REQ-003 SHALL have port iSystemClock, in, 1: clock; all logic on its rising edge.
REQ-004 SHALL have port iReset, in, 1: synchronous, active-high reset.
REQ-005 SHALL have command-in ports, all in: iOpcode 6, iTargetID 5, iSourceID 5, iAddress 32, iLength 16, iCMDValid 1.
REQ-006 SHALL have port oCMDReady, out, 1: block idle and able to accept a command.
REQ-007 SHALL have port oStatus, out, 24: completion record.
REQ-008 SHALL have port oStatusValid, out, 1: oStatus is valid this cycle.
REQ-009 SHALL have port iReadyBusy, in, NumberOfWays: per-way R/B#, where 1 means ready.
REQ-010 SHALL have engine ports, all out: oEngOpcode 6, oEngWaySelect NumberOfWays (one-hot), oEngAddress 32, oEngLength 16, oEngStart 1.
REQ-011 SHALL have engine ports, all in: iEngDone 1 (one-cycle pulse) and iEngStatus 8.

Function
REQ-012 SHALL be a Moore FSM with states IDLE, CHECK, WAITRB, ISSUE, EXEC, REPORT; oCMDReady=1 only in IDLE, oEngStart=1 only in ISSUE, oStatusValid=1 only in REPORT.
REQ-013 SHALL accept a command on the edge where iCMDValid && oCMDReady: latch all command fields and move IDLE->CHECK; iSourceID is latched and ignored.
REQ-014 SHALL ignore iCMDValid and all command inputs in every state other than IDLE.
REQ-015 SHALL, in CHECK, move to REPORT with code 1 if target >= NumberOfWays, else to REPORT with code 2 if opcode == 0, else to WAITRB; the target check takes precedence.
REQ-016 SHALL, in WAITRB, move to ISSUE on the first cycle iReadyBusy[target]==1.
REQ-017 SHALL, in ISSUE, drive oEngOpcode/oEngAddress/oEngLength from latched fields and oEngWaySelect=1<<target, then move to EXEC.
REQ-018 SHALL hold the oEng* data outputs stable from ISSUE until leaving EXEC, and drive them 0 in all other states.
REQ-019 SHALL, in EXEC, capture iEngStatus on iEngDone and move to REPORT with code 0.
REQ-020 SHALL ignore iEngDone outside EXEC.
REQ-021 SHALL format oStatus as [23:16] engine status (0 unless code 0), [15:10] opcode, [9:5] target, [4:0] code (0 ok, 1 bad target, 2 bad opcode, 3 timeout).
REQ-022 SHALL hold oStatus until the next REPORT.
REQ-023 SHALL pulse oStatusValid for exactly one cycle per accepted command, then move REPORT->IDLE.
REQ-024 SHALL meet this latency for acceptance at edge 0 with the way ready: oEngStart high in cycle 3; oStatusValid in the cycle after iEngDone; oCMDReady high the cycle after REPORT.
REQ-025 SHALL, for an invalid command accepted at edge 0, assert oStatusValid in cycle 2.

Reset
REQ-026 SHALL, while iReset=1, force state IDLE, oCMDReady=0, oStatusValid=0, oEngStart=0, oStatus=0, all oEng* outputs=0, latched fields=0 and the timeout counter=0.
REQ-027 SHALL, on reset during any state (including EXEC), abandon the operation with no status pulse, and oCMDReady SHALL rise the first cycle after iReset falls.

Configuration
REQ-028 SHALL, with macro NFC_CMD_TIMEOUT_EN defined, run a 16-bit counter that clears on entry to WAITRB and to EXEC, increments each cycle in those states, and on reaching TimeoutCycles moves to REPORT with code 3 and engine status 0.
REQ-029 SHALL, with NFC_CMD_TIMEOUT_EN defined, give iEngDone priority over timeout in the same cycle (code 0).
REQ-030 SHALL, without NFC_CMD_TIMEOUT_EN, omit the counter, wait in WAITRB and EXEC indefinitely, and never produce code 3.

Verification
REQ-031 SHALL cover nominal flow: opcode 0x05, target 1, addr 0x00012345, len 0x0800, way ready, iEngDone with status 0xE0 two cycles after start -> oEngStart in cycle 3, oEngWaySelect=2'b10, oStatus=0xE01420.
REQ-032 SHALL cover bad target: target 3 with NumberOfWays=2, opcode 0x05 -> oStatusValid in cycle 2, oStatus=0x001461, no oEngStart.
REQ-033 SHALL cover R/B wait: iReadyBusy[0]=0 for 10 cycles after acceptance -> oEngStart one cycle after R/B rises; commands during busy are ignored (oCMDReady=0).
REQ-034 SHALL cover timeout (macro on, TimeoutCycles=20): no iEngDone -> code 3 after 20 EXEC cycles; with done and timeout in the same cycle -> code 0.
REQ-035 SHALL cover reset in EXEC: iReset for 1 cycle -> oStatusValid never pulses, oCMDReady=1 the next cycle, and a following command completes normally.
